fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage for the 16-bit CPU. Holds the program counter, requests instructions from instruction memory over a req/ready handshake, and registers the fetched word into the IF/ID boundary. It drives the 4-bit opcode consumed by the control decoder. It accepts stall from decode and branch redirects from the downstream branch-resolution logic, which acts on the decoder's branch/beq/bl/br outputs.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction request; address valid while high
- imem_addr  out  16  word address of requested instruction (= pc)
- imem_rdata  in  16  instruction word; valid only when imem_ready=1
- imem_ready  in  1  memory returns imem_rdata for this cycle's imem_addr
- stall  in  1  decode cannot accept a new instruction this cycle
- branch_taken  in  1  redirect PC this cycle (resolved b/beq/bl/br)
- branch_target  in  16  new PC when branch_taken=1
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  16  registered instruction word
- if_opcode  out  4  if_instr[15:12]; drives the control decoder
- if_pc  out  16  address of if_instr
- link_pc  out  16  if_pc + 1 (mod 2^16); return address for bl
- fetch_count  out  16  number of instructions delivered with if_valid=1; wraps

## Operation
- The PC is word-addressed. Sequential next PC = pc + 1, with 16-bit wrap: 16'hFFFF -> 16'h0000.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; a captured word waits in the skid register.
- FETCH, in priority order, after redirect:
  - imem_ready=1 and stall=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1, fetch_count+1.
  - imem_ready=1 and stall=1: skid<=imem_rdata, skid_pc<=pc, IF outputs unchanged, go to HOLD.
  - imem_ready=0 and stall=0: if_valid<=0 (bubble), pc unchanged.
  - imem_ready=0 and stall=1: all outputs held.
- HOLD:
  - stall=1: hold everything.
  - stall=0: if_instr<=skid, if_pc<=skid_pc, if_valid<=1, pc<=skid_pc+1, fetch_count+1, go to FETCH.
- Redirect: branch_taken=1 has highest priority in every state, including when stall=1.
  - pc<=branch_target, if_valid<=0, skid discarded, state<=FETCH.
  - An imem response in the same cycle is dropped and fetch_count does not increment.
- While if_valid=0, consumers ignore if_opcode; if_instr retains its last value except after reset.
- link_pc and if_opcode are combinational from the registered if_pc and if_instr.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, fetch_count=0, skid=0. imem_req is 0 during any cycle with rst=1 and 1 in the first cycle after reset.
- Latency: a word returned with imem_ready in cycle N appears on if_instr/if_valid in cycle N+1.
- Throughput: with zero-wait memory (ready same cycle as req), one instruction per cycle.
- Handshake: imem_addr is stable while imem_req=1 and ready=0, unless a redirect occurs. A redirect abandons the outstanding request, and memory must tolerate the address change.
- Stall: IF outputs are frozen in the stall cycle and every following stall cycle. No instruction is lost or duplicated across stall.
- Reset asserted mid-operation (including in HOLD): next cycle returns to reset values and the skid is discarded.

## Test plan
- Reset, RESET_PC=16'h0010, zero-wait memory returning 16'h1000+addr:
  - if_valid rises in cycle 2 with if_pc=0x0010, if_instr=0x1010, if_opcode=4'h1.
  - Consecutive cycles give 0x0011 and 0x0012; link_pc = if_pc+1.
- Memory with 2 wait states: if_valid pulses once every 3 cycles; pc advances only on ready; imem_addr is stable while waiting.
- stall=1 for 3 cycles coinciding with ready at pc=0x0005: FSM enters HOLD, imem_req=0. On stall release, if_pc=0x0005, then 0x0006 follows; no skips or duplicates; fetch_count is exact.
- branch_taken=1, target 0x0040, while in HOLD with stall=1: next cycle if_valid=0, state FETCH, imem_addr=0x0040. The first valid instruction after that has if_pc=0x0040, and the skid word never appears.
- Sequential fetch at pc=0xFFFF: the following fetch address is 0x0000; link_pc for if_pc=0xFFFF is 0x0000. fetch_count preset near 0xFFFF wraps to 0.
- rst asserted for one cycle mid-stream with ready=1: the response is dropped, outputs return to reset values, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic [15:0] rdata;
  logic        ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, one-entry skid for stalls,
// and the registered IF/ID boundary feeding the control decoder.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  fetch_stage_if.master       imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [15:0]         branch_target,
  output logic                if_valid,
  output logic [15:0]         if_instr,
  output logic [3:0]          if_opcode,
  output logic [15:0]         if_pc,
  output logic [15:0]         link_pc,
  output logic [15:0]         fetch_count
);

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned OPW = 4;

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc;
  logic [DW-1:0] skid;
  logic [AW-1:0] skid_pc;

  logic capture;   // deliver imem word straight to IF/ID
  logic park;      // imem word arrived under stall; keep it in the skid
  logic unpark;    // stall released in HOLD; deliver skid word
  logic bubble;    // no word this cycle; invalidate IF/ID

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic; a redirect always returns to FETCH
  always_comb begin
    state_next = state;
    if (branch_taken) begin
      state_next = FETCH;
    end else begin
      case (state)
        FETCH: if (imem.ready && stall) state_next = HOLD;
        HOLD:  if (!stall)              state_next = FETCH;
      endcase
    end
  end

  // Output / action decode
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = pc;
    capture   = 1'b0;
    park      = 1'b0;
    unpark    = 1'b0;
    bubble    = 1'b0;
    case (state)
      FETCH: begin
        imem.req = !rst;
        if (!branch_taken) begin
          if (imem.ready && !stall)     capture = 1'b1;
          else if (imem.ready && stall) park    = 1'b1;
          else if (!stall)              bubble  = 1'b1;
        end
      end
      HOLD: begin
        if (!branch_taken && !stall) unpark = 1'b1;
      end
    endcase
  end

  // PC, skid and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
      skid        <= '0;
      skid_pc     <= '0;
    end else if (branch_taken) begin
      pc       <= branch_target;
      if_valid <= 1'b0;
    end else if (capture) begin
      if_instr    <= imem.rdata;
      if_pc       <= pc;
      if_valid    <= 1'b1;
      pc          <= pc + AW'(1);
      fetch_count <= fetch_count + 16'(1);
    end else if (park) begin
      skid    <= imem.rdata;
      skid_pc <= pc;
    end else if (unpark) begin
      if_instr    <= skid;
      if_pc       <= skid_pc;
      if_valid    <= 1'b1;
      pc          <= skid_pc + AW'(1);
      fetch_count <= fetch_count + 16'(1);
    end else if (bubble) begin
      if_valid <= 1'b0;
    end
  end

  assign if_opcode = if_instr[DW-1 -: OPW];
  assign link_pc   = if_pc + AW'(1);

endmodule
